// File: rtl/ix_sb_issue_pkg.sv
// Shared definitions for the scoreboarded issue stage: default sizes,
// functional-unit index constants and decode payload field layout.
package ix_sb_issue_pkg;

  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;
  localparam int NFU_DEF  = 2;
  localparam int PW_DEF   = 16;

  // Functional-unit indices as seen on dec_fu / ix_fu_valid bit positions.
  localparam int FU_INT = 0;
  localparam int FU_LSP = 1;

  // Payload field offsets; the issue stage forwards the payload untouched,
  // these only document how decode and the FUs agree to pack it.
  localparam int PL_OP_LSB   = 0;
  localparam int PL_OP_W     = 6;
  localparam int PL_OPT_LSB  = 6;
  localparam int PL_OPT_W    = 4;
  localparam int PL_MEMW_LSB = 10;
  localparam int PL_MEMW_W   = 2;

  // Memory access width encoding carried in the payload memw field.
  typedef enum logic [1:0] {
    MEMW_B = 2'd0,
    MEMW_H = 2'd1,
    MEMW_W = 2'd2,
    MEMW_D = 2'd3
  } memw_e;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ix_sb_issue_if.sv
// Decode, dispatch and writeback channels of the issue stage.
// slave = issue stage view, master = decode / functional-unit side.
interface ix_sb_issue_if #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NFU  = 2,
  parameter int PW   = 16
);
  localparam int RW  = $clog2(NREG);
  localparam int FUW = ix_sb_issue_pkg::idx_w(NFU);

  // decode -> issue
  logic                 dec_valid;
  logic                 dec_ready;
  logic [XLEN-1:0]      dec_pc;
  logic [XLEN-1:0]      dec_imm;
  logic [PW-1:0]        dec_payload;
  logic [FUW-1:0]       dec_fu;
  logic [RW-1:0]        dec_rs1;
  logic [RW-1:0]        dec_rs2;
  logic                 dec_rs1_en;
  logic                 dec_rs2_en;
  logic [RW-1:0]        dec_rd;
  logic                 dec_wb_en;

  // issue -> functional units
  logic [NFU-1:0]       ix_fu_valid;
  logic [NFU-1:0]       ix_fu_ready;
  logic [XLEN-1:0]      ix_fu_pc;
  logic [XLEN-1:0]      ix_fu_imm;
  logic [XLEN-1:0]      ix_fu_rs1_val;
  logic [XLEN-1:0]      ix_fu_rs2_val;
  logic [RW-1:0]        ix_fu_dst;
  logic                 ix_fu_wb_en;
  logic [PW-1:0]        ix_fu_payload;

  // functional units -> writeback
  logic [NFU-1:0]       fu_wb_valid;
  logic [NFU-1:0]       fu_wb_ready;
  logic [NFU*RW-1:0]    fu_wb_dst;
  logic [NFU*XLEN-1:0]  fu_wb_result;
  logic [NFU*XLEN-1:0]  fu_wb_pc;

  modport slave (
    input  dec_valid, dec_pc, dec_imm, dec_payload, dec_fu,
           dec_rs1, dec_rs2, dec_rs1_en, dec_rs2_en, dec_rd, dec_wb_en,
    output dec_ready,
    output ix_fu_valid, ix_fu_pc, ix_fu_imm, ix_fu_rs1_val, ix_fu_rs2_val,
           ix_fu_dst, ix_fu_wb_en, ix_fu_payload,
    input  ix_fu_ready,
    input  fu_wb_valid, fu_wb_dst, fu_wb_result, fu_wb_pc,
    output fu_wb_ready
  );

  modport master (
    output dec_valid, dec_pc, dec_imm, dec_payload, dec_fu,
           dec_rs1, dec_rs2, dec_rs1_en, dec_rs2_en, dec_rd, dec_wb_en,
    input  dec_ready,
    input  ix_fu_valid, ix_fu_pc, ix_fu_imm, ix_fu_rs1_val, ix_fu_rs2_val,
           ix_fu_dst, ix_fu_wb_en, ix_fu_payload,
    output ix_fu_ready,
    output fu_wb_valid, fu_wb_dst, fu_wb_result, fu_wb_pc,
    input  fu_wb_ready
  );

endinterface

// File: rtl/ix_sb_issue_rr_arb.sv
// Round-robin arbiter over NFU requesters. Search starts at the pointer;
// the pointer moves past the winner only when i_advance accepts a grant.
// Grants are suppressed while rst is low.
module ix_sb_issue_rr_arb #(
  parameter int NFU = 2,
  parameter int FUW = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NFU-1:0] i_req,
  input  logic           i_advance,
  output logic [NFU-1:0] o_grant,
  output logic [FUW-1:0] o_idx,
  output logic           o_any
);

  logic [FUW-1:0] r_ptr;
  logic [NFU-1:0] w_req;
  logic [NFU-1:0] w_grant;
  logic [FUW-1:0] w_idx;
  logic           w_any;

  assign w_req = rst ? i_req : '0;

  // Pick the first requester at or after the pointer, wrapping at NFU.
  always_comb begin
    int  w_k;
    logic w_hit;
    w_grant = '0;
    w_idx   = '0;
    w_any   = 1'b0;
    w_k     = 0;
    w_hit   = 1'b0;
    for (int i = 0; i < NFU; i++) begin
      w_k = int'(r_ptr) + i;
      w_k = (w_k >= NFU) ? (w_k - NFU) : w_k;
      w_hit = !w_any && w_req[w_k];
      w_grant[w_k] = w_hit;
      w_idx = w_hit ? FUW'(w_k) : w_idx;
      w_any = w_any | w_hit;
    end
  end

  // Pointer advances to the slot after the winner; held when idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (i_advance && w_any) begin
      r_ptr <= (int'(w_idx) == NFU - 1) ? '0 : FUW'(int'(w_idx) + 1);
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign o_grant = w_grant;
  assign o_idx   = w_idx;
  assign o_any   = w_any;

endmodule

// File: rtl/ix_sb_issue.sv
// Scoreboarded issue stage: register file, busy bits, single-entry
// dispatch register shared by all FUs, round-robin writeback.
// Optional macro IX_BYPASS_EN forwards the granted writeback value into
// operand select and the availability check in the same cycle.
module ix_sb_issue
  import ix_sb_issue_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NFU  = NFU_DEF,
  parameter int PW   = PW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  ix_sb_issue_if.slave  bus
);

  localparam int RW  = $clog2(NREG);
  localparam int FUW = idx_w(NFU);

  // Register file (never reset) and scoreboard.
  logic [XLEN-1:0] r_rf [NREG];
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;

  // Dispatch register.
  logic [NFU-1:0]  r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_rs1_val;
  logic [XLEN-1:0] r_rs2_val;
  logic [RW-1:0]   r_dst;
  logic            r_wb_en;
  logic [PW-1:0]   r_payload;

  // Writeback selection.
  logic [NFU-1:0]  w_wb_gnt;
  logic [FUW-1:0]  w_wb_idx;
  logic            w_wb_any;
  logic [RW-1:0]   w_wb_dst;
  logic [XLEN-1:0] w_wb_res;
  logic            w_fwd_vld;

  // Issue decision.
  logic            w_free;
  logic            w_fire;
  logic            w_fu_ok;
  logic            w_av_rs1;
  logic            w_av_rs2;
  logic            w_av_rd;
  logic            w_issue;
  logic            w_set;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic            w_unused_pc;

  ix_sb_issue_rr_arb #(.NFU(NFU), .FUW(FUW)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (bus.fu_wb_valid),
    .i_advance (1'b1),
    .o_grant   (w_wb_gnt),
    .o_idx     (w_wb_idx),
    .o_any     (w_wb_any)
  );

  assign w_wb_dst = bus.fu_wb_dst[int'(w_wb_idx)*RW +: RW];
  assign w_wb_res = bus.fu_wb_result[int'(w_wb_idx)*XLEN +: XLEN];
  assign bus.fu_wb_ready = w_wb_gnt;
  assign w_unused_pc = ^bus.fu_wb_pc;

`ifdef IX_BYPASS_EN
  assign w_fwd_vld = w_wb_any;
`else
  assign w_fwd_vld = 1'b0;
`endif

  // Operand source: x0 reads zero, then a matching forward, then the rf.
  function automatic logic [XLEN-1:0] f_opsel(
    input logic [RW-1:0]   r,
    input logic            fwd,
    input logic [RW-1:0]   fdst,
    input logic [XLEN-1:0] fres,
    input logic [XLEN-1:0] rfv
  );
    if (r == '0) begin
      return '0;
    end else if (fwd && (fdst == r)) begin
      return fres;
    end else begin
      return rfv;
    end
  endfunction

  assign w_av_rs1 = (bus.dec_rs1 == '0) || !r_busy[bus.dec_rs1] ||
                    (w_fwd_vld && (w_wb_dst == bus.dec_rs1));
  assign w_av_rs2 = (bus.dec_rs2 == '0) || !r_busy[bus.dec_rs2] ||
                    (w_fwd_vld && (w_wb_dst == bus.dec_rs2));
  assign w_av_rd  = (bus.dec_rd == '0) || !r_busy[bus.dec_rd] ||
                    (w_fwd_vld && (w_wb_dst == bus.dec_rd));

  assign w_fire  = (r_valid & bus.ix_fu_ready) != '0;
  assign w_free  = (r_valid == '0) || w_fire;
  assign w_fu_ok = int'(bus.dec_fu) < NFU;
  assign w_issue = rst && bus.dec_valid && w_free && w_fu_ok &&
                   (!bus.dec_rs1_en || w_av_rs1) &&
                   (!bus.dec_rs2_en || w_av_rs2) &&
                   (!bus.dec_wb_en  || w_av_rd);
  assign bus.dec_ready = rst && !(bus.dec_valid && !w_issue);
  assign w_set = w_issue && bus.dec_wb_en && (bus.dec_rd != '0);

  assign w_rs1_val = f_opsel(bus.dec_rs1, w_fwd_vld, w_wb_dst, w_wb_res, r_rf[bus.dec_rs1]);
  assign w_rs2_val = f_opsel(bus.dec_rs2, w_fwd_vld, w_wb_dst, w_wb_res, r_rf[bus.dec_rs2]);

  // Busy update: grant clears, issue sets, set wins on the same register.
  always_comb begin
    w_busy_nxt = '0;
    for (int r = 1; r < NREG; r++) begin
      w_busy_nxt[r] = (r_busy[r] & ~(w_wb_any && (w_wb_dst == RW'(r)))) |
                      (w_set && (bus.dec_rd == RW'(r)));
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Granted writeback lands in the rf; writes to x0 are dropped.
  always_ff @(posedge clk) begin
    if (w_wb_any && (w_wb_dst != '0)) begin
      r_rf[w_wb_dst] <= w_wb_res;
    end
  end

  // Dispatch valid: load on issue, drop on handshake, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= '0;
    end else if (w_issue) begin
      r_valid <= NFU'(1'b1) << bus.dec_fu;
    end else if (w_fire) begin
      r_valid <= '0;
    end else begin
      r_valid <= r_valid;
    end
  end

  // Dispatch payload: captured on issue and frozen until the next issue.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc      <= '0;
      r_imm     <= '0;
      r_rs1_val <= '0;
      r_rs2_val <= '0;
      r_dst     <= '0;
      r_wb_en   <= 1'b0;
      r_payload <= '0;
    end else if (w_issue) begin
      r_pc      <= bus.dec_pc;
      r_imm     <= bus.dec_imm;
      r_rs1_val <= w_rs1_val;
      r_rs2_val <= w_rs2_val;
      r_dst     <= bus.dec_rd;
      r_wb_en   <= bus.dec_wb_en;
      r_payload <= bus.dec_payload;
    end else begin
      r_pc      <= r_pc;
      r_imm     <= r_imm;
      r_rs1_val <= r_rs1_val;
      r_rs2_val <= r_rs2_val;
      r_dst     <= r_dst;
      r_wb_en   <= r_wb_en;
      r_payload <= r_payload;
    end
  end

  assign bus.ix_fu_valid   = r_valid;
  assign bus.ix_fu_pc      = r_pc;
  assign bus.ix_fu_imm     = r_imm;
  assign bus.ix_fu_rs1_val = r_rs1_val;
  assign bus.ix_fu_rs2_val = r_rs2_val;
  assign bus.ix_fu_dst     = r_dst;
  assign bus.ix_fu_wb_en   = r_wb_en;
  assign bus.ix_fu_payload = r_payload;

endmodule
